// File: rtl/branch_resolve_pipe.sv
// Branch resolution in EX with fetch redirect and ID/EX flush, plus one-shot predictor update from MEM.
// Optional perf counters (branches retired to MEM, mispredicts) are compiled in with BRANCH_PERF_CNT_EN.
module branch_resolve_pipe (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        id_valid,
    input  logic        id_is_branch,
    input  logic        id_predict_btaken,
    input  logic [5:0]  id_pht_idx,
    input  logic [31:0] id_q_pc,
    input  logic        stall_i,
    input  logic        ex_branch_cond,
    input  logic [31:0] ex_btarget,
    output logic        ex_redirect_valid,
    output logic [31:0] ex_redirect_pc,
    output logic        mem_q_is_branch,
    output logic        mem_q_jump_taken,
    output logic [5:0]  mem_q_pht_idx
`ifdef BRANCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_branch_cnt,
    output logic [31:0] perf_mispred_cnt
`endif
);

    typedef struct packed {
        logic        valid;
        logic        is_branch;
        logic        predict;
        logic [5:0]  pht_idx;
        logic [31:0] pc;
    } idex_t;

    typedef struct packed {
        logic       is_branch;
        logic       taken;
        logic [5:0] pht_idx;
    } exmem_t;

    idex_t  idex_q, idex_d;
    exmem_t exmem_q, exmem_d;
    logic   upd_done_q, upd_done_d;
    logic   mispredict;

    always_comb begin
        mispredict = idex_q.valid & idex_q.is_branch & (ex_branch_cond != idex_q.predict);
        ex_redirect_valid = mispredict & ~stall_i;
        ex_redirect_pc = ex_branch_cond ? ex_btarget : (idex_q.pc + 32'd4);
        mem_q_is_branch = exmem_q.is_branch & ~upd_done_q;
        mem_q_jump_taken = exmem_q.taken;
        mem_q_pht_idx = exmem_q.pht_idx;
    end

    // A mispredict turns the wrong-path ID instruction into a bubble; a stall defers that.
    always_comb begin
        idex_d = idex_q;
        if (!stall_i) begin
            if (mispredict) begin
                idex_d = '0;
            end else begin
                idex_d.valid = id_valid;
                idex_d.is_branch = id_is_branch;
                idex_d.predict = id_predict_btaken;
                idex_d.pht_idx = id_pht_idx;
                idex_d.pc = id_q_pc;
            end
        end
    end

    // upd_done keeps a stalled MEM branch from updating the predictor twice.
    always_comb begin
        exmem_d = exmem_q;
        upd_done_d = upd_done_q;
        if (!stall_i) begin
            exmem_d.is_branch = idex_q.valid & idex_q.is_branch;
            exmem_d.taken = ex_branch_cond;
            exmem_d.pht_idx = idex_q.pht_idx;
            upd_done_d = 1'b0;
        end else if (mem_q_is_branch) begin
            upd_done_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            idex_q <= '0;
            exmem_q <= '0;
            upd_done_q <= 1'b0;
        end else begin
            idex_q <= idex_d;
            exmem_q <= exmem_d;
            upd_done_q <= upd_done_d;
        end
    end

`ifdef BRANCH_PERF_CNT_EN
    logic [31:0] perf_branch_cnt_q, perf_branch_cnt_d;
    logic [31:0] perf_mispred_cnt_q, perf_mispred_cnt_d;

    always_comb begin
        perf_branch_cnt_d = perf_branch_cnt_q + {31'd0, mem_q_is_branch};
        perf_mispred_cnt_d = perf_mispred_cnt_q + {31'd0, ex_redirect_valid};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            perf_branch_cnt_q <= '0;
            perf_mispred_cnt_q <= '0;
        end else begin
            perf_branch_cnt_q <= perf_branch_cnt_d;
            perf_mispred_cnt_q <= perf_mispred_cnt_d;
        end
    end

    assign perf_branch_cnt = perf_branch_cnt_q;
    assign perf_mispred_cnt = perf_mispred_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve_pipe.sv
// Scoreboard bench for branch_resolve_pipe: driver runs an instruction-level model and queues
// expected redirect/update events; a negedge monitor compares whatever the DUT presents.
module tb_branch_resolve_pipe;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        id_valid = 1'b0;
    logic        id_is_branch = 1'b0;
    logic        id_predict_btaken = 1'b0;
    logic [5:0]  id_pht_idx = '0;
    logic [31:0] id_q_pc = '0;
    logic        stall_i = 1'b0;
    logic        ex_branch_cond = 1'b0;
    logic [31:0] ex_btarget = '0;
    logic        ex_redirect_valid;
    logic [31:0] ex_redirect_pc;
    logic        mem_q_is_branch;
    logic        mem_q_jump_taken;
    logic [5:0]  mem_q_pht_idx;
`ifdef BRANCH_PERF_CNT_EN
    logic [31:0] perf_branch_cnt;
    logic [31:0] perf_mispred_cnt;
`endif

    branch_resolve_pipe dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .id_valid(id_valid),
        .id_is_branch(id_is_branch),
        .id_predict_btaken(id_predict_btaken),
        .id_pht_idx(id_pht_idx),
        .id_q_pc(id_q_pc),
        .stall_i(stall_i),
        .ex_branch_cond(ex_branch_cond),
        .ex_btarget(ex_btarget),
        .ex_redirect_valid(ex_redirect_valid),
        .ex_redirect_pc(ex_redirect_pc),
        .mem_q_is_branch(mem_q_is_branch),
        .mem_q_jump_taken(mem_q_jump_taken),
        .mem_q_pht_idx(mem_q_pht_idx)
`ifdef BRANCH_PERF_CNT_EN
        ,
        .perf_branch_cnt(perf_branch_cnt),
        .perf_mispred_cnt(perf_mispred_cnt)
`endif
    );

    always #5 clk_i = ~clk_i;

    // Instruction currently resolving in EX, and the branch record sitting in MEM.
    typedef struct {
        bit        v;
        bit        br;
        bit        pred;
        bit [5:0]  idx;
        bit [31:0] pc;
    } ins_t;
    typedef struct {
        int        cyc;
        bit [31:0] pc;
    } rd_t;
    typedef struct {
        int       cyc;
        bit       tk;
        bit [5:0] idx;
    } up_t;

    ins_t     m_ex = '{0, 0, 0, 0, 0};
    bit       m_mem_br = 0;
    bit       m_mem_tk = 0;
    bit [5:0] m_mem_idx = 0;
    bit       m_mem_reported = 0;
    int       m_br_cnt = 0;
    int       m_mis_cnt = 0;
    rd_t      rd_q[$];
    up_t      up_q[$];
    int       cyc = 0;
    int       checks = 0;
    int       errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input logic rst, input logic v, input logic br, input logic pred,
                        input logic [5:0] idx, input logic [31:0] pc, input logic stall,
                        input logic cond, input logic [31:0] bt);
        bit mis, red, upd;
        @(posedge clk_i);
        #1;
`ifdef BRANCH_PERF_CNT_EN
        chk("perf_branch_cnt", perf_branch_cnt, m_br_cnt);
        chk("perf_mispred_cnt", perf_mispred_cnt, m_mis_cnt);
`endif
        rst_ni = rst;
        id_valid = v;
        id_is_branch = br;
        id_predict_btaken = pred;
        id_pht_idx = idx;
        id_q_pc = pc;
        stall_i = stall;
        ex_branch_cond = cond;
        ex_btarget = bt;
        cyc++;
        mis = m_ex.v && m_ex.br && (cond != m_ex.pred);
        red = mis && !stall;
        upd = m_mem_br && !m_mem_reported;
        if (rst) begin
            if (red) rd_q.push_back('{cyc, cond ? bt : m_ex.pc + 32'd4});
            if (upd) up_q.push_back('{cyc, m_mem_tk, m_mem_idx});
            m_br_cnt += int'(upd);
            m_mis_cnt += int'(red);
            if (!stall) begin
                m_mem_br = m_ex.v && m_ex.br;
                m_mem_tk = cond;
                m_mem_idx = m_ex.idx;
                m_mem_reported = 0;
                if (red) m_ex = '{0, 0, 0, 0, 0};
                else m_ex = '{v, br, pred, idx, pc};
            end else if (upd) begin
                m_mem_reported = 1;
            end
        end else begin
            m_ex = '{0, 0, 0, 0, 0};
            m_mem_br = 0;
            m_mem_tk = 0;
            m_mem_idx = 0;
            m_mem_reported = 0;
            m_br_cnt = 0;
            m_mis_cnt = 0;
        end
    endtask

    task automatic idle(input logic cond);
        step(1, 0, 0, 0, 0, 0, 0, cond, 32'h0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        @(negedge clk_i);
        chk({tag, "_redirect_valid"}, ex_redirect_valid, 0);
        chk({tag, "_redirect_pc"}, ex_redirect_pc, 32'h4);
        chk({tag, "_mem_is_branch"}, mem_q_is_branch, 0);
        chk({tag, "_mem_taken"}, mem_q_jump_taken, 0);
        chk({tag, "_mem_idx"}, mem_q_pht_idx, 0);
    endtask

    // Monitor: skips reset cycles, otherwise compares any presented or expected strobe.
    initial begin
        bit exp_r, exp_u;
        forever begin
            @(negedge clk_i);
            if (rst_ni === 1'b1) begin
                exp_r = (rd_q.size() > 0) && (rd_q[0].cyc == cyc);
                if (ex_redirect_valid !== 1'b0 || exp_r) begin
                    chk("redirect_valid", ex_redirect_valid, exp_r);
                    if (exp_r) begin
                        if (ex_redirect_valid === 1'b1) chk("redirect_pc", ex_redirect_pc, rd_q[0].pc);
                        void'(rd_q.pop_front());
                    end
                end
                exp_u = (up_q.size() > 0) && (up_q[0].cyc == cyc);
                if (mem_q_is_branch !== 1'b0 || exp_u) begin
                    chk("update_strobe", mem_q_is_branch, exp_u);
                    if (exp_u) begin
                        if (mem_q_is_branch === 1'b1) begin
                            chk("update_taken", mem_q_jump_taken, up_q[0].tk);
                            chk("update_idx", mem_q_pht_idx, up_q[0].idx);
                        end
                        void'(up_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        bit p4[4];
        bit c4[4];
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(0);
        chk_reset_outputs("reset");

        // Correctly predicted taken branch, update two cycles later.
        step(1, 1, 1, 1, 6'd5, 32'h100, 0, 0, 0);
        idle(1);
        idle(0);
        idle(0);

        // Not-taken prediction resolves taken; trailing branch must be flushed.
        step(1, 1, 1, 0, 6'd7, 32'h200, 0, 0, 0);
        step(1, 1, 1, 0, 6'd11, 32'h300, 0, 1, 32'h400);
        idle(1);
        idle(0);
        idle(0);

        // Fall-through address wraps.
        step(1, 1, 1, 1, 6'd3, 32'hFFFF_FFFC, 0, 0, 0);
        idle(0);
        idle(0);
        idle(0);

        // Branch A held in MEM and mispredicted branch B held in EX across a 3-cycle stall.
        step(1, 1, 1, 1, 6'd8, 32'h4F0, 0, 0, 0);
        step(1, 1, 1, 0, 6'd9, 32'h500, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 1, 1, 32'h800);
        step(1, 0, 0, 0, 0, 0, 1, 1, 32'h800);
        step(1, 0, 0, 0, 0, 0, 1, 1, 32'h800);
        step(1, 0, 0, 0, 0, 0, 0, 1, 32'h800);
        idle(0);
        idle(0);

        // Reset while a mispredict sits in EX.
        step(1, 1, 1, 0, 6'd12, 32'h600, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 1, 32'h900);
        idle(0);
        chk_reset_outputs("reset_mid");

        // Four branches, the last one mispredicted.
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        p4 = '{1, 0, 1, 0};
        c4 = '{1, 0, 1, 1};
        for (int i = 0; i < 5; i++) begin
            if (i < 4) step(1, 1, 1, p4[i], 6'(i + 20), 32'h1000 + 32'(i * 4), 0, i > 0 ? c4[i-1] : 1'b0, 32'h2000);
            else step(1, 0, 0, 0, 0, 0, 0, c4[3], 32'h2000);
        end
        idle(0);
        idle(0);
        idle(0);
`ifdef BRANCH_PERF_CNT_EN
        @(negedge clk_i);
        chk("perf_branch_4", perf_branch_cnt, 32'd4);
        chk("perf_mispred_1", perf_mispred_cnt, 32'd1);
`endif

        for (int n = 0; n < 800; n++) begin
            step($urandom_range(63) != 0, 1'($urandom), 1'($urandom), 1'($urandom),
                 6'($urandom), $urandom, $urandom_range(3) == 0, 1'($urandom), $urandom);
        end
        idle(0);
        idle(0);
        idle(0);
        @(negedge clk_i);
        chk("redirect_queue_drained", rd_q.size(), 0);
        chk("update_queue_drained", up_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_resolve_pipe.md
BRANCH_RESOLVE_PIPE -- requirements
Module: branch_resolve_pipe

Interface
REQ-001 SHALL have port clk_i  in  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_ni  in  1  reset, synchronous, active-low.
REQ-003 SHALL have port id_valid  in  1  ID holds a valid instruction.
REQ-004 SHALL have port id_is_branch  in  1  the ID instruction is a conditional branch.
REQ-005 SHALL have port id_predict_btaken  in  1  predictor taken/not-taken for the ID branch.
REQ-006 SHALL have port id_pht_idx  in  6  predictor table index used for the ID branch.
REQ-007 SHALL have port id_q_pc  in  32  PC of the ID instruction.
REQ-008 SHALL have port stall_i  in  1  pipeline stall; holds the ID/EX and EX/MEM registers.
REQ-009 SHALL have port ex_branch_cond  in  1  resolved branch outcome from the EX ALU.
REQ-010 SHALL have port ex_btarget  in  32  resolved taken target from EX.
REQ-011 SHALL have port ex_redirect_valid  out  1  one-cycle fetch redirect strobe.
REQ-012 SHALL have port ex_redirect_pc  out  32  redirect destination.
REQ-013 SHALL have port mem_q_is_branch  out  1  predictor update strobe.
REQ-014 SHALL have port mem_q_jump_taken  out  1  resolved outcome for the update.
REQ-015 SHALL have port mem_q_pht_idx  out  6  table index for the update.
REQ-016 SHALL have ports perf_branch_cnt and perf_mispred_cnt  out  32 each; these exist only with the macro in REQ-033.

Function
REQ-017 SHALL hold ID/EX fields: valid, is_branch, predict, pht_idx, pc.
- Loaded from ID inputs each cycle when stall_i=0 and no mispredict.
REQ-018 SHALL compute mispredict (combinational) as EX valid AND EX is_branch AND (ex_branch_cond != EX predict).
REQ-019 SHALL drive ex_redirect_valid = mispredict AND NOT stall_i.
- It is a single-cycle pulse per mispredicted branch, including when stall is held for N cycles.
REQ-020 SHALL drive ex_redirect_pc = ex_branch_cond ? ex_btarget : EX pc + 32'd4.
- The add is 32-bit and wraps modulo 2^32 (0xFFFFFFFC -> 0x00000000).
REQ-021 SHALL load a bubble into ID/EX on the cycle after ex_redirect_valid, discarding the wrong-path ID instruction.
- Flush has priority over the ID load.
REQ-022 SHALL hold all ID/EX contents when stall_i=1; flush is deferred until the stall releases.
REQ-023 SHALL hold EX/MEM fields: is_branch (EX valid AND EX is_branch), taken (ex_branch_cond), pht_idx.
- Loaded when stall_i=0; held when stall_i=1.
REQ-024 SHALL assert mem_q_is_branch for exactly one cycle per branch entering MEM, via an update-done flag.
- The flag is set after the first strobe cycle and cleared when a new EX/MEM value loads.
- A branch held in MEM by a stall updates the predictor once only.
REQ-025 SHALL drive mem_q_jump_taken and mem_q_pht_idx from EX/MEM at all times; both are meaningful only while mem_q_is_branch=1.
REQ-026 SHALL treat a non-branch or invalid instruction as producing no redirect and no update strobe.
REQ-027 SHALL still advance EX/MEM normally on a mispredict cycle, so the mispredicted branch itself updates the predictor.
REQ-028 SHALL give a back-to-back branch behind a mispredicted branch no redirect, because it is flushed (REQ-021).

Reset
REQ-029 SHALL, when rst_ni=0 at a clock edge, clear ID/EX valid and is_branch, EX/MEM is_branch, and the update-done flag.
REQ-030 SHALL, in reset, zero pc, pht_idx, predict and taken fields, and zero both perf counters.
REQ-031 SHALL drive these output values from reset: ex_redirect_valid=0, ex_redirect_pc=32'h4, mem_q_is_branch=0, mem_q_jump_taken=0, mem_q_pht_idx=0.
REQ-032 SHALL let reset override stall_i and any in-flight mispredict; no redirect or update strobe occurs in the cycle after reset.

Configuration
REQ-033 SHALL compile the perf counters in when macro BRANCH_PERF_CNT_EN is defined.
- perf_branch_cnt increments on each mem_q_is_branch strobe.
- perf_mispred_cnt increments on each ex_redirect_valid.
- Both are 32-bit and wrap to 0.
REQ-034 SHALL, without BRANCH_PERF_CNT_EN, omit both ports and both counter registers; all other behaviour is identical.

Verification
REQ-035 Bench SHALL cover: branch pc=0x100, predict=1, cond=1, pht_idx=5, no stall -> no redirect; two cycles later mem_q_is_branch=1, taken=1, idx=5 for one cycle.
REQ-036 Bench SHALL cover: branch pc=0x200, predict=0, cond=1, btarget=0x400 -> ex_redirect_valid=1, ex_redirect_pc=0x400; the next ID/EX is a bubble.
REQ-037 Bench SHALL cover: predict=1, cond=0, pc=0xFFFFFFFC -> redirect to 0x00000000.
REQ-038 Bench SHALL cover: mispredicted branch in EX with stall_i=1 for 3 cycles -> redirect pulses once, on release; the MEM update strobe fires once.
REQ-039 Bench SHALL cover: rst_ni=0 asserted while a mispredict sits in EX -> next cycle all strobes are 0 and outputs match REQ-031.
REQ-040 Bench SHALL cover, with BRANCH_PERF_CNT_EN: 4 branches with 1 mispredict -> perf_branch_cnt=4, perf_mispred_cnt=1.
